fifo_checker: RTL and testbench
===============================

FIFO_CHECKER -- requirements
Module: fifo_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the monitored FIFO data bus.
REQ-002 Parameter FIFO_DEPTH, default 8, entries in the monitored FIFO; legal range 2..256.
REQ-003 Parameter AF_TH, default FIFO_DEPTH-1, model count at or above which almostfull is expected.
REQ-004 Parameter AE_TH, default 1, model count at or below which almostempty is expected, excluding count 0.
REQ-005 Parameter ERR_CNT_W, default 8, error counter width.
REQ-006 Parameter STOP_ON_ERR, default 0; when 1, checking halts after the first error.
REQ-007 Ports: clk in 1, the single clock; rst_n in 1, asynchronous active-low reset.
REQ-008 Ports: chk_en in 1, checking enable; clear_err in 1, clears sticky errors and the counter.
REQ-009 Ports: wr_en in 1, rd_en in 1, data_in in DATA_WIDTH: FIFO request inputs, as driven to the monitored FIFO.
REQ-010 Ports: data_out in DATA_WIDTH, wr_ack in 1, overflow in 1, underflow in 1: registered FIFO responses.
REQ-011 Ports: full in 1, empty in 1, almostfull in 1, almostempty in 1: combinational FIFO flags.
REQ-012 Ports: err_flags out 8, sticky per-check errors; err_any out 1, OR of err_flags; err_cnt out ERR_CNT_W, saturating error-cycle count.
REQ-013 Ports: first_err out 3, index of the lowest set bit in the first erroring cycle; model_count out clog2(FIFO_DEPTH+1), shadow occupancy; halted out 1.

Function
REQ-014 Model write accepted when wr_en=1 and model_count<FIFO_DEPTH; model read accepted when rd_en=1 and model_count>0.
REQ-015 When both are accepted in one cycle, model_count is unchanged; otherwise +1 per write and -1 per read.
REQ-016 Expected flags each cycle, from model_count: full=(count==FIFO_DEPTH), empty=(count==0), almostfull=(count>=AF_TH and count<FIFO_DEPTH), almostempty=(count>0 and count<=AE_TH).
REQ-017 Expected responses one cycle after a request: wr_ack=accepted write, overflow=(wr_en and model full), underflow=(rd_en and model empty).
REQ-018 err_flags bit map: 0 full, 1 empty, 2 almostfull, 3 almostempty, 4 wr_ack, 5 overflow, 6 underflow, 7 data.
REQ-019 The FSM has states OFF, ARMED, CHECK and HALT; OFF->ARMED when chk_en=1, ARMED->CHECK after one cycle, any state->OFF when chk_en=0.
REQ-020 In OFF and ARMED, the model tracks the traffic but no compare is made, so stale registered responses are never flagged.
REQ-021 In CHECK, a mismatch sets the matching err_flags bit on the next clock edge; err_cnt increments once per erroring cycle and saturates at all-ones.
REQ-022 first_err loads only while err_any=0; later errors do not change it.
REQ-023 With STOP_ON_ERR=1, the first error moves CHECK->HALT; in HALT, compares stop, the model keeps tracking and halted=1.
REQ-024 clear_err=1 zeroes err_flags, err_cnt and first_err, and moves HALT->CHECK; clear_err has priority over an error set in the same cycle.
REQ-025 model_count wraps never; the pointers into the shadow storage wrap modulo FIFO_DEPTH.

Reset
REQ-026 rst_n=0 immediately forces state OFF, model_count=0, pointers=0, err_flags=0, err_cnt=0, first_err=0 and halted=0.
REQ-027 Reset asserted mid-traffic discards all model contents; the checker resumes from ARMED after rst_n=1 and chk_en=1.

Configuration
REQ-028 Macro FIFO_CHK_DATA_EN defined: a FIFO_DEPTH x DATA_WIDTH shadow memory stores accepted writes, and data_out is compared one cycle after each accepted read, with a mismatch setting bit 7.
REQ-029 Macro FIFO_CHK_DATA_EN undefined: no shadow memory is built, and err_flags[7] is tied to 0.

Verification
REQ-030 DEPTH=8: 8 writes then 1 more -> model_count=8, expected full=1, overflow=1 on the 10th cycle; correct FIFO gives err_any=0.
REQ-031 Empty FIFO, rd_en=1 -> underflow expected next cycle; a FIFO driving underflow=0 sets err_flags[6] and err_cnt=1, and first_err=6.
REQ-032 Count=0 with wr_en=rd_en=1 -> write only, model_count=1, and almostempty expected 1 in the next cycle.
REQ-033 STOP_ON_ERR=1: force full stuck at 0 when count=8 -> bit 0 set, halted=1, err_cnt stays 1 under further faults; clear_err -> all cleared, CHECK resumes.
REQ-034 FIFO_CHK_DATA_EN: write 0xA5A5 then read with data_out=0x0000 -> err_flags[7]=1 one cycle after the read; with the macro undefined, err_flags[7]=0.
REQ-035 Pulse rst_n low mid-burst at count=5 -> all outputs 0 asynchronously, and after re-enable the first 8 writes raise no errors.

Source files
------------

// File: rtl/fifo_checker_if.sv
// Bus of the monitored FIFO: requests, registered responses and combinational flags.
// The master side is the FIFO environment; the checker observes through the slave side.
interface fifo_checker_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;

    modport master (
        output wr_en, rd_en, data_in, data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty
    );

    modport slave (
        input  wr_en, rd_en, data_in, data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty
    );
endinterface

// File: rtl/fifo_checker.sv
// Shadow-model protocol checker for a synchronous FIFO: tracks occupancy, predicts flags and
// responses, and records sticky mismatches. Define FIFO_CHK_DATA_EN to also check read data.
module fifo_checker #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int AF_TH       = FIFO_DEPTH - 1,
    parameter int AE_TH       = 1,
    parameter int ERR_CNT_W   = 8,
    parameter bit STOP_ON_ERR = 1'b0,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chk_en,
    input  logic                 clear_err,
    fifo_checker_if.slave        fifo,
    output logic [7:0]           err_flags,
    output logic                 err_any,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [2:0]           first_err,
    output logic [CNT_W-1:0]     model_count,
    output logic                 halted
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ARMED,
        ST_CHECK,
        ST_HALT
    } state_e;

    state_e               state_q, state_d;
    logic                 halted_q, halted_d;
    logic [CNT_W-1:0]     model_count_q, model_count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                 exp_ack_q, exp_ack_d;
    logic                 exp_ovf_q, exp_ovf_d;
    logic                 exp_udf_q, exp_udf_d;
    logic [7:0]           err_flags_q, err_flags_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [2:0]           first_err_q, first_err_d;

    logic       wr_acc, rd_acc;
    logic       model_full, model_empty;
    logic       exp_af, exp_ae;
    logic       data_mism;
    logic [7:0] mism;
    logic       err_hit;

    function automatic logic [2:0] lowest_bit(input logic [7:0] v);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_bit = 3'(i);
        end
    endfunction

    // Shadow occupancy model; it runs in every state so the first compare after arming is valid.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        model_full    = (model_count_q == CNT_W'(FIFO_DEPTH));
        model_empty   = (model_count_q == '0);
        exp_af        = (model_count_q >= CNT_W'(AF_TH)) && !model_full;
        exp_ae        = !model_empty && (model_count_q <= CNT_W'(AE_TH));
        wr_acc        = fifo.wr_en && !model_full;
        rd_acc        = fifo.rd_en && !model_empty;
        exp_ack_d     = wr_acc;
        exp_ovf_d     = fifo.wr_en && model_full;
        exp_udf_d     = fifo.rd_en && model_empty;
        model_count_d = model_count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (wr_acc && !rd_acc) model_count_d = model_count_q + CNT_W'(1);
        if (rd_acc && !wr_acc) model_count_d = model_count_q - CNT_W'(1);
        if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

`ifdef FIFO_CHK_DATA_EN
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
    logic                  rd_vld_q, rd_vld_d;

    // NOTE: the shadow storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= fifo.data_in;
    end

    always_comb begin
        rd_vld_d   = rd_acc;
        exp_data_d = exp_data_q;
        if (rd_acc) exp_data_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q   <= 1'b0;
            exp_data_q <= '0;
        end else begin
            rd_vld_q   <= rd_vld_d;
            exp_data_q <= exp_data_d;
        end
    end

    assign data_mism = rd_vld_q && (fifo.data_out != exp_data_q);
`else
    logic unused_data;
    assign unused_data = ^{fifo.data_in, fifo.data_out, wr_ptr_q, rd_ptr_q};
    assign data_mism   = 1'b0;
`endif

    assign mism = {data_mism,
                   fifo.underflow   != exp_udf_q,
                   fifo.overflow    != exp_ovf_q,
                   fifo.wr_ack      != exp_ack_q,
                   fifo.almostempty != exp_ae,
                   fifo.almostfull  != exp_af,
                   fifo.empty       != model_empty,
                   fifo.full        != model_full};

    // clear_err wins over an error detected in the same cycle, so that cycle is not recorded.
    always_comb begin
        err_hit     = (state_q == ST_CHECK) && (mism != 8'h00) && !clear_err;
        err_flags_d = err_flags_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (clear_err) begin
            err_flags_d = '0;
            err_cnt_d   = '0;
            first_err_d = '0;
        end else if (err_hit) begin
            err_flags_d = err_flags_q | mism;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            if (err_flags_q == 8'h00) first_err_d = lowest_bit(mism);
        end
    end

    always_comb begin
        state_d = state_q;
        if (!chk_en) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF:   state_d = ST_ARMED;
                ST_ARMED: state_d = ST_CHECK;
                ST_CHECK: if (STOP_ON_ERR && err_hit) state_d = ST_HALT;
                ST_HALT:  if (clear_err) state_d = ST_CHECK;
            endcase
        end
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_OFF;
            halted_q      <= 1'b0;
            model_count_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            exp_ack_q     <= 1'b0;
            exp_ovf_q     <= 1'b0;
            exp_udf_q     <= 1'b0;
            err_flags_q   <= '0;
            err_cnt_q     <= '0;
            first_err_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q       <= state_d;
            halted_q      <= halted_d;
            model_count_q <= model_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            exp_ack_q     <= exp_ack_d;
            exp_ovf_q     <= exp_ovf_d;
            exp_udf_q     <= exp_udf_d;
            err_flags_q   <= err_flags_d;
            err_cnt_q     <= err_cnt_d;
            first_err_q   <= first_err_d;
        end
    end

    assign err_flags   = err_flags_q;
    assign err_any     = |err_flags_q;
    assign err_cnt     = err_cnt_q;
    assign first_err   = first_err_q;
    assign model_count = model_count_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fifo_checker.sv
// Directed bench for fifo_checker: a well-behaved FIFO emulator drives the bus, and a per-cycle
// fault mask corrupts chosen flags/responses so every expected checker output is a hand constant.
module tb_fifo_checker;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
`ifdef FIFO_CHK_DATA_EN
    localparam bit DATA_EN = 1'b1;
`else
    localparam bit DATA_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chk_en = 1'b0, clear_err = 1'b0;
    logic       chk_en_s = 1'b0, clear_err_s = 1'b0;
    logic [7:0] err_flags, err_flags_s;
    logic       err_any, err_any_s;
    logic [7:0] err_cnt, err_cnt_s;
    logic [2:0] first_err, first_err_s;
    logic [3:0] model_count, model_count_s;
    logic       halted, halted_s;

    int n_checks = 0;
    int n_errors = 0;

    fifo_checker_if #(.DATA_WIDTH(DW)) fifo ();

    fifo_checker #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clear_err(clear_err), .fifo(fifo),
        .err_flags(err_flags), .err_any(err_any), .err_cnt(err_cnt), .first_err(first_err),
        .model_count(model_count), .halted(halted)
    );

    fifo_checker #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STOP_ON_ERR(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en_s), .clear_err(clear_err_s), .fifo(fifo),
        .err_flags(err_flags_s), .err_any(err_any_s), .err_cnt(err_cnt_s), .first_err(first_err_s),
        .model_count(model_count_s), .halted(halted_s)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Emulated FIFO that behaves correctly; faults are layered on when driving the bus.
    int          fcount = 0;
    logic [15:0] fq[$];
    logic        r_ack = 1'b0, r_ovf = 1'b0, r_udf = 1'b0;
    logic [15:0] r_data = '0;

    typedef struct {
        logic        chk;
        logic        clr;
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [7:0]  fault;
        logic [3:0]  e_cnt;
        logic [7:0]  e_flags;
        logic [7:0]  e_ecnt;
        logic [2:0]  e_first;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bus(input logic wr, input logic rd, input logic [15:0] din,
                             input logic [7:0] fault);
        fifo.wr_en       = wr;
        fifo.rd_en       = rd;
        fifo.data_in     = din;
        fifo.full        = (fcount == DEPTH) ^ fault[0];
        fifo.empty       = (fcount == 0) ^ fault[1];
        fifo.almostfull  = (fcount >= DEPTH - 1 && fcount < DEPTH) ^ fault[2];
        fifo.almostempty = (fcount > 0 && fcount <= 1) ^ fault[3];
        fifo.wr_ack      = r_ack ^ fault[4];
        fifo.overflow    = r_ovf ^ fault[5];
        fifo.underflow   = r_udf ^ fault[6];
        fifo.data_out    = fault[7] ? 16'h0000 : r_data;
    endtask

    task automatic step(input logic wr, input logic rd, input logic [15:0] din,
                        input logic [7:0] fault);
        logic wa, ra;
        @(negedge clk);
        drive_bus(wr, rd, din, fault);
        @(posedge clk);
        wa    = wr && (fcount < DEPTH);
        ra    = rd && (fcount > 0);
        r_ack = wa;
        r_ovf = wr && (fcount == DEPTH);
        r_udf = rd && (fcount == 0);
        if (ra) r_data = fq.pop_front();
        if (wa) fq.push_back(din);
        fcount = fq.size();
        #1;
    endtask

    task automatic reset_emulator();
        fcount = 0;
        fq.delete();
        r_ack  = 1'b0;
        r_ovf  = 1'b0;
        r_udf  = 1'b0;
        r_data = '0;
        drive_bus(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic check_main(input string tag, input logic [3:0] cnt, input logic [7:0] flags,
                              input logic [7:0] ecnt, input logic [2:0] first);
        check({tag, " model_count"}, 32'(model_count), 32'(cnt));
        check({tag, " err_flags"},   32'(err_flags),   32'(flags));
        check({tag, " err_any"},     32'(err_any),     32'(flags != 8'h00));
        check({tag, " err_cnt"},     32'(err_cnt),     32'(ecnt));
        check({tag, " first_err"},   32'(first_err),   32'(first));
        check({tag, " halted"},      32'(halted),      32'(0));
    endtask

    task automatic check_stop(input string tag, input logic [3:0] cnt, input logic [7:0] flags,
                              input logic [7:0] ecnt, input logic [2:0] first, input logic halt);
        check({tag, " s.model_count"}, 32'(model_count_s), 32'(cnt));
        check({tag, " s.err_flags"},   32'(err_flags_s),   32'(flags));
        check({tag, " s.err_any"},     32'(err_any_s),     32'(flags != 8'h00));
        check({tag, " s.err_cnt"},     32'(err_cnt_s),     32'(ecnt));
        check({tag, " s.first_err"},   32'(first_err_s),   32'(first));
        check({tag, " s.halted"},      32'(halted_s),      32'(halt));
    endtask

    task automatic add(input logic chk, input logic clr, input logic wr, input logic rd,
                       input logic [15:0] din, input logic [7:0] fault, input logic [3:0] cnt,
                       input logic [7:0] flags, input logic [7:0] ecnt, input logic [2:0] first);
        vecs.push_back('{chk, clr, wr, rd, din, fault, cnt, flags, ecnt, first});
    endtask

    initial begin
        // Arm, fill to 8, overflow, drain with data compare, underflow.
        add(1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 8; i++) add(1, 0, 1, 0, 16'h1000 + 16'(i), 8'h00, 4'(i), 8'h00, 0, 0);
        add(1, 0, 1, 0, 16'h1009, 8'h00, 8, 8'h00, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 8'h00, 8, 8'h00, 0, 0);
        for (int i = 7; i >= 0; i--) add(1, 0, 0, 1, 16'h0000, 8'h00, 4'(i), 8'h00, 0, 0);
        add(1, 0, 0, 1, 16'h0000, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0);
        // Missing underflow, then write-only on simultaneous request at empty, missing almostempty.
        add(1, 0, 0, 1, 16'h0000, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 8'h40, 0, 8'h40, 1, 6);
        add(1, 0, 1, 1, 16'hA5A5, 8'h00, 1, 8'h40, 1, 6);
        add(1, 0, 0, 0, 16'h0000, 8'h08, 1, 8'h48, 2, 6);
        // clear_err beats a same-cycle fault; two bits in one cycle count once.
        add(1, 1, 0, 0, 16'h0000, 8'h01, 1, 8'h00, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 8'h04, 1, 8'h04, 1, 2);
        add(1, 0, 0, 0, 16'h0000, 8'h12, 1, 8'h16, 2, 2);
        add(1, 1, 0, 0, 16'h0000, 8'h00, 1, 8'h00, 0, 0);
        // Disabled and re-arming cycles must not compare.
        add(0, 0, 0, 0, 16'h0000, 8'h00, 1, 8'h00, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 8'h01, 1, 8'h00, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 8'h01, 1, 8'h00, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 8'h01, 1, 8'h00, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 8'h01, 1, 8'h01, 1, 0);
        add(1, 1, 0, 0, 16'h0000, 8'h00, 1, 8'h00, 0, 0);
        // Read back 0xA5A5 but present 0x0000.
        add(1, 0, 0, 1, 16'h0000, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 8'h80, 0, DATA_EN ? 8'h80 : 8'h00,
            DATA_EN ? 8'd1 : 8'd0, DATA_EN ? 3'd7 : 3'd0);

        reset_emulator();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_main("reset", 0, 8'h00, 0, 0);
        check_stop("reset", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            chk_en    = vecs[i].chk;
            clear_err = vecs[i].clr;
            step(vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].fault);
            check_main($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_flags,
                       vecs[i].e_ecnt, vecs[i].e_first);
        end

        // Error counter saturation.
        chk_en    = 1'b1;
        clear_err = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 8'h00);
        clear_err = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            step(1'b0, 1'b0, 16'h0000, 8'h01);
            if (k == 255) check_main("sat255", 0, 8'h01, 8'd255, 0);
        end
        check_main("sat260", 0, 8'h01, 8'd255, 0);

        // Stop-on-error: full stuck low at count 8.
        chk_en   = 1'b0;
        chk_en_s = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 8'h00);
        step(1'b0, 1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h2000 + 16'(i), 8'h00);
        check_stop("stop_fill", 8, 8'h00, 0, 0, 0);
        step(1'b0, 1'b0, 16'h0000, 8'h01);
        check_stop("stop_hit", 8, 8'h01, 1, 0, 1);
        step(1'b0, 1'b1, 16'h0000, 8'h0F);
        step(1'b0, 1'b0, 16'h0000, 8'h0F);
        step(1'b0, 1'b0, 16'h0000, 8'h0F);
        check_stop("stop_halt", 7, 8'h01, 1, 0, 1);
        clear_err_s = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 8'h00);
        check_stop("stop_clear", 7, 8'h00, 0, 0, 0);
        clear_err_s = 1'b0;
        step(1'b0, 1'b0, 16'h0000, 8'h02);
        check_stop("stop_resume", 7, 8'h02, 1, 1, 1);

        // Asynchronous reset mid-burst at count 5.
        chk_en_s = 1'b0;
        step(1'b0, 1'b1, 16'h0000, 8'h00);
        step(1'b0, 1'b1, 16'h0000, 8'h00);
        check("pre_reset count", 32'(model_count), 32'(5));
        #2;
        rst_n = 1'b0;
        reset_emulator();
        #1;
        check_main("async_rst", 0, 8'h00, 0, 0);
        check_stop("async_rst", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 8'h00);
        step(1'b0, 1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'h3000 + 16'(i), 8'h00);
            check($sformatf("post_rst wr%0d err_any", i), 32'(err_any), 32'(0));
        end
        check_main("post_rst", 8, 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
